// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe register pipeline
// and its sibling datapath blocks.
package reg_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid bit and a data word.
// Clear wins over load; data only moves when a valid word arrives.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            v <= v_in;
            if (v_in) d <= d_in;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// Enable-gated register pipeline with per-stage valid bits,
// valid/ready handshake, synchronous flush and occupancy count.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       s_valid,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       s_ready,
    output logic                       m_valid,
    output logic [WIDTH-1:0]           m_data,
    input  logic                       m_ready,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic                        in_xfer;
    logic                        out_xfer;
    logic                        adv;
    logic                        clr;

    // A bubble anywhere downstream lets every stage above it advance.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = ~v[DEPTH-1] | m_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = ~v[i] | rdy[i+1];
        end
    end

    assign adv      = en & ~flush;
    assign clr      = en & flush;
    assign s_ready  = adv & rdy[0];
    assign m_valid  = v[DEPTH-1];
    assign m_data   = d[DEPTH-1];
    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & m_ready & adv;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = s_valid;
            assign up_d = s_data;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (adv & rdy[i]),
            .clear (clr),
            .v_in  (up_v),
            .d_in  (up_d),
            .v     (v[i]),
            .d     (d[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (in_xfer & ~out_xfer) begin
            count <= count + CW'(1);
        end else if (out_xfer & ~in_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// Randomised and directed bench for reg_pipe against a slot/queue
// reference model.
module tb_reg_pipe;

    localparam int D = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       flush;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] count;

    int checks;
    int errors;

    // slot[k] < 0 means empty; otherwise the word held there.
    int slot [D];
    int exp_q [$];

    reg_pipe #(
        .WIDTH     (8),
        .DEPTH     (D),
        .RESET_VAL (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic int occ();
        int n = 0;
        for (int k = 0; k < D; k++) if (slot[k] >= 0) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) slot[k] = -1;
        exp_q.delete();
    endtask

    // One clock: drive, check against model, advance model, clock.
    task automatic cyc(input bit sv, input logic [7:0] sd,
                       input bit mr, input bit e, input bit fl);
        int  j;
        bit  mv;
        bit  sr;
        int  top;
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        en      = e;
        flush   = fl;
        #1;
        mv = slot[D-1] >= 0;
        // j: furthest position that can take a word this edge
        if (mv && mr) begin
            j = D;
        end else begin
            j = -1;
            for (int k = 0; k < D; k++) if (slot[k] < 0) j = k;
        end
        sr = e && !fl && j >= 0;
        chk("s_ready", 32'(s_ready), 32'(sr));
        chk("m_valid", 32'(m_valid), 32'(mv));
        if (mv) chk("m_data", 32'(m_data), 32'(slot[D-1]));
        chk("count", 32'(count), 32'(occ()));
        if (e && fl) begin
            model_clear();
        end else if (e) begin
            if (mv && mr) begin
                chk("order", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (sv && sr) exp_q.push_back(int'(sd));
            if (j >= 0) begin
                top = (j == D) ? D - 1 : j;
                for (int k = top; k >= 1; k--) slot[k] = slot[k-1];
                slot[0] = sv ? int'(sd) : -1;
            end
        end
        @(posedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 1, 1, 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        en      = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        model_clear();
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'h0FF);
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(1));
        @(negedge clk);
        reset = 1'b0;

        // streaming 0x11..0x33
        cyc(1, 8'h11, 1, 1, 0);
        cyc(1, 8'h22, 1, 1, 0);
        cyc(1, 8'h33, 1, 1, 0);
        drain(4);

        // fill while stalled, then drain with 0xA4 waiting
        cyc(1, 8'hA1, 0, 1, 0);
        cyc(1, 8'hA2, 0, 1, 0);
        cyc(1, 8'hA3, 0, 1, 0);
        cyc(1, 8'hA4, 0, 1, 0);
        cyc(1, 8'hA4, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'hA4, 1, 1, 0);
        drain(4);

        // freeze with en low
        cyc(1, 8'h05, 0, 1, 0);
        cyc(1, 8'h06, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'h99, 1, 0, 0);
        drain(5);

        // flush with two words inside and 0x77 presented
        cyc(1, 8'h01, 0, 1, 0);
        cyc(1, 8'h02, 0, 1, 0);
        cyc(1, 8'h77, 1, 1, 1);
        drain(4);

        // async reset between edges with a full pipe
        cyc(1, 8'hB1, 0, 1, 0);
        cyc(1, 8'hB2, 0, 1, 0);
        cyc(1, 8'hB3, 0, 1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'(0));
        chk("arst_m_data", 32'(m_data), 32'h0FF);
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_s_ready", 32'(s_ready), 32'(1));
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1, 8'h3C, 1, 1, 0);
        drain(4);

        // bubble pattern with toggling m_ready
        cyc(1, 8'h01, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(1, 8'h02, 1, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        drain(5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 8'($urandom),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 7) != 0,
                $urandom_range(0, 29) == 0);
        end
        drain(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
